zap_predecode_bp: RTL and testbench
===================================

Name: zap_predecode_bp

Overview:
Parametrised decode-stage branch predictor with its own pipeline register, placed between the coprocessor/memory-FSM predecode logic and the issue stage.
- Predictions come from an internal branch history table (BHT) of 2-bit saturating counters indexed by PC. The previous scheme relied only on a 2-bit state supplied from outside.
- The BHT is trained by branch resolutions reported from the ALU.
- On a predicted-taken branch the block issues a front-end redirect.
- After reset it runs a table-initialisation sweep.

Parameters:
BP_ENTRIES, 1024, number of BHT entries; power of two, minimum 4.
INSN_W, 35, instruction width; bit INSN_W-1 is the halfword-offset flag (shift of 1).
INIT_STATE, 1, counter value written at init (0=SNT, 1=WNT, 2=WT, 3=ST).

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_clear_from_writeback  in  1  flush, highest priority
i_data_stall  in  1  hold
i_clear_from_alu  in  1  flush
i_stall_from_shifter  in  1  hold
i_stall_from_issue  in  1  hold, lowest priority
i_pc_ff  in  32  PC of incoming instruction
i_pc_plus_8_ff  in  32  PC+8 of incoming instruction
i_instruction  in  INSN_W  instruction from predecode
i_instruction_valid  in  1  instruction valid
i_upd_valid  in  1  ALU resolved a branch this cycle
i_upd_pc  in  32  PC of resolved branch
i_upd_taken  in  1  resolved direction
o_instruction_ff  out  INSN_W  registered instruction
o_instruction_valid_ff  out  1  registered valid
o_pc_ff  out  32  registered PC
o_pc_plus_8_ff  out  32  registered PC+8
o_taken_ff  out  2  registered prediction state sent down the pipe
o_clear_from_decode  out  1  combinational redirect request
o_pc_from_decode  out  32  combinational redirect target
o_stall_from_decode  out  1  stall fetch (asserted during init)
o_init_done  out  1  BHT sweep complete

Behaviour:
- Index: idx(pc) = pc[log2(BP_ENTRIES)+1:2]. Used for both lookup (i_pc_ff) and update (i_upd_pc).
- FSM states:
  - INIT: entered on reset. Sweep counter starts at 0 and writes INIT_STATE to one entry per cycle, for BP_ENTRIES cycles.
  - RUN: entered after the write to entry BP_ENTRIES-1.
  - Reset asserted in any state, including mid-sweep, restarts INIT at entry 0.
  - o_init_done=0 and o_stall_from_decode=1 throughout INIT; 0 and 1 respectively are swapped in RUN (o_init_done=1, o_stall_from_decode=0).
  - Updates and predictions are ignored during INIT.
- Update (RUN, i_upd_valid=1): the counter at idx(i_upd_pc) saturates up if i_upd_taken, down otherwise (3 stays 3, 0 stays 0). Write takes effect at the next clock edge.
- Lookup read bypass: if the same cycle has an update to idx(i_pc_ff), the lookup uses the post-update value.
- Branch detect: i_instruction[27:25]==3'b101 and i_instruction_valid.
- Target computation:
  - offset = sign-extend(i_instruction[23:0]) to 32 bits, shifted left 1 if bit INSN_W-1 is set, else left 2.
  - target = i_pc_plus_8_ff + offset, modulo 2^32 (wraps).
- Predict taken when counter[1]=1 or cond[31:28]==4'b1110 (AL).
- Prediction state: taken_nxt = 2'b11 if AL, else the counter value. Non-branches pass taken_nxt = counter value.
- Redirect: o_clear_from_decode=1 and o_pc_from_decode=target only when all of the following hold:
  - branch detected and predicted taken;
  - state is RUN;
  - no clear or stall input is asserted.
  Otherwise o_clear_from_decode=0 and o_pc_from_decode=0.
- Pipeline register priority (highest first):
  - reset → clear;
  - i_clear_from_writeback → clear;
  - i_data_stall → hold;
  - i_clear_from_alu → clear;
  - i_stall_from_shifter → hold;
  - i_stall_from_issue → hold;
  - in INIT → register valid 0;
  - otherwise load all inputs and taken_nxt.
- Clear action: o_instruction_valid_ff=0, o_taken_ff=0, o_instruction_ff[27]=0. Other data bits are don't-care, and PCs retain their value.
- Reset values: o_instruction_valid_ff=0, o_taken_ff=0, o_instruction_ff=0, o_pc_ff=0, o_pc_plus_8_ff=0, o_init_done=0, o_stall_from_decode=1.
- Latency: prediction and redirect in the same cycle as the input; registered outputs after 1 cycle; BHT training is visible to lookups in the same cycle via the bypass.

Test Plan:
- Reset, BP_ENTRIES=16: o_stall_from_decode=1 for exactly 16 cycles, then o_init_done=1; pulse reset at cycle 8 → sweep restarts, 16 more cycles required.
- AL branch 0xEA000002 at pc=0x100 (pc+8=0x108) → o_clear_from_decode=1, o_pc_from_decode=0x110, next cycle o_taken_ff=3.
- Conditional BEQ 0x0AFFFFFE at pc=0x200, counter at init value 1 → no redirect, o_taken_ff=1; after two updates taken at 0x200 → counter 3, redirect to 0x200.
- Same-cycle update taken and lookup at idx 5, counter at 1 → lookup sees 2 → redirect asserted; four not-taken updates → counter saturates at 0.
- Halfword flag set, imm24=0xFFFFFF, pc+8=0x0 → target 0xFFFFFFFE (wraps).
- Branch with i_data_stall=1 → no redirect and register held; with i_clear_from_writeback and i_data_stall both 1 → o_instruction_valid_ff=0.

Source files
------------

// File: rtl/zap_predecode_bp.sv
// rtl/zap_predecode_bp.sv - decode-stage branch predictor with BHT, init sweep and pipeline register
module zap_predecode_bp #(
    parameter int BP_ENTRIES = 1024,
    parameter int INSN_W     = 35,
    parameter int INIT_STATE = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear_from_writeback,
    input  logic              i_data_stall,
    input  logic              i_clear_from_alu,
    input  logic              i_stall_from_shifter,
    input  logic              i_stall_from_issue,
    input  logic [31:0]       i_pc_ff,
    input  logic [31:0]       i_pc_plus_8_ff,
    input  logic [INSN_W-1:0] i_instruction,
    input  logic              i_instruction_valid,
    input  logic              i_upd_valid,
    input  logic [31:0]       i_upd_pc,
    input  logic              i_upd_taken,
    output logic [INSN_W-1:0] o_instruction_ff,
    output logic              o_instruction_valid_ff,
    output logic [31:0]       o_pc_ff,
    output logic [31:0]       o_pc_plus_8_ff,
    output logic [1:0]        o_taken_ff,
    output logic              o_clear_from_decode,
    output logic [31:0]       o_pc_from_decode,
    output logic              o_stall_from_decode,
    output logic              o_init_done
);
    localparam int IDX_W = $clog2(BP_ENTRIES);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  sweep_cnt_q;
    logic              init_done_q;
    logic              stall_q;
    logic [1:0]        bht_q [BP_ENTRIES];

    logic              run;
    logic [IDX_W-1:0]  lk_idx, upd_idx, bht_waddr;
    logic [1:0]        upd_old, upd_new, bht_wdata, ctr, taken_nxt;
    logic              bht_we, is_branch, is_al, pred_taken, any_hold;
    logic [31:0]       imm_ext, offset, target;
    logic              unused_upd_pc;

    assign run     = (state_q == S_RUN);
    assign lk_idx  = i_pc_ff[IDX_W+1:2];
    assign upd_idx = i_upd_pc[IDX_W+1:2];
    assign unused_upd_pc = ^{i_upd_pc[31:IDX_W+2], i_upd_pc[1:0]};

    // FSM: sweep one BHT entry per cycle after reset, then run
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_INIT;
            sweep_cnt_q <= '0;
            init_done_q <= 1'b0;
            stall_q     <= 1'b1;
        end else begin
            case (state_q)
                S_INIT: begin
                    sweep_cnt_q <= sweep_cnt_q + IDX_W'(1);
                    if (sweep_cnt_q == IDX_W'(BP_ENTRIES - 1)) begin
                        state_q     <= S_RUN;
                        init_done_q <= 1'b1;
                        stall_q     <= 1'b0;
                    end
                end
                S_RUN:   state_q <= S_RUN;
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign o_init_done         = init_done_q;
    assign o_stall_from_decode = stall_q;

    always_comb begin
        upd_old = bht_q[upd_idx];
        upd_new = upd_old;
        if (i_upd_taken && upd_old != 2'd3)
            upd_new = upd_old + 2'd1;
        else if (!i_upd_taken && upd_old != 2'd0)
            upd_new = upd_old - 2'd1;
    end

    always_comb begin
        bht_we    = 1'b0;
        bht_waddr = upd_idx;
        bht_wdata = upd_new;
        if (!run) begin
            bht_we    = 1'b1;
            bht_waddr = sweep_cnt_q;
            bht_wdata = INIT_STATE[1:0];
        end else if (i_upd_valid) begin
            bht_we = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (bht_we)
            bht_q[bht_waddr] <= bht_wdata;
    end

    // Lookup sees a same-cycle training write to the same entry
    always_comb begin
        ctr = bht_q[lk_idx];
        if (run && i_upd_valid && upd_idx == lk_idx)
            ctr = upd_new;
    end

    always_comb begin
        is_branch  = i_instruction_valid && (i_instruction[27:25] == 3'b101);
        is_al      = (i_instruction[31:28] == 4'b1110);
        pred_taken = ctr[1] || is_al;
        taken_nxt  = (is_branch && is_al) ? 2'b11 : ctr;
        imm_ext    = {{8{i_instruction[23]}}, i_instruction[23:0]};
        offset     = i_instruction[INSN_W-1] ? (imm_ext << 1) : (imm_ext << 2);
        target     = i_pc_plus_8_ff + offset;
        any_hold   = i_clear_from_writeback || i_data_stall || i_clear_from_alu ||
                     i_stall_from_shifter || i_stall_from_issue;
    end

    assign o_clear_from_decode = is_branch && pred_taken && run && !any_hold;
    assign o_pc_from_decode    = o_clear_from_decode ? target : 32'd0;

    logic [INSN_W-1:0] insn_q, insn_d;
    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d, pc8_q, pc8_d;
    logic [1:0]        taken_q, taken_d;

    always_comb begin
        insn_d  = insn_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        pc8_d   = pc8_q;
        taken_d = taken_q;
        if (i_clear_from_writeback) begin
            valid_d    = 1'b0;
            taken_d    = 2'b00;
            insn_d[27] = 1'b0;
        end else if (i_data_stall) begin
            valid_d = valid_q;
        end else if (i_clear_from_alu) begin
            valid_d    = 1'b0;
            taken_d    = 2'b00;
            insn_d[27] = 1'b0;
        end else if (i_stall_from_shifter || i_stall_from_issue) begin
            valid_d = valid_q;
        end else if (!run) begin
            valid_d = 1'b0;
        end else begin
            insn_d  = i_instruction;
            valid_d = i_instruction_valid;
            pc_d    = i_pc_ff;
            pc8_d   = i_pc_plus_8_ff;
            taken_d = taken_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            insn_q  <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc8_q   <= '0;
            taken_q <= 2'b00;
        end else begin
            insn_q  <= insn_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pc8_q   <= pc8_d;
            taken_q <= taken_d;
        end
    end

    assign o_instruction_ff       = insn_q;
    assign o_instruction_valid_ff = valid_q;
    assign o_pc_ff                = pc_q;
    assign o_pc_plus_8_ff         = pc8_q;
    assign o_taken_ff             = taken_q;
endmodule

// File: tb/tb_zap_predecode_bp.sv
// tb/tb_zap_predecode_bp.sv - directed self-checking bench for zap_predecode_bp
module tb_zap_predecode_bp;
    localparam int INSN_W = 35;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_clear_from_writeback, i_data_stall, i_clear_from_alu;
    logic              i_stall_from_shifter, i_stall_from_issue;
    logic [31:0]       i_pc_ff, i_pc_plus_8_ff, i_upd_pc;
    logic [INSN_W-1:0] i_instruction;
    logic              i_instruction_valid, i_upd_valid, i_upd_taken;
    logic [INSN_W-1:0] o_instruction_ff;
    logic              o_instruction_valid_ff, o_clear_from_decode;
    logic              o_stall_from_decode, o_init_done;
    logic [31:0]       o_pc_ff, o_pc_plus_8_ff, o_pc_from_decode;
    logic [1:0]        o_taken_ff;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    zap_predecode_bp #(.BP_ENTRIES(16), .INSN_W(INSN_W), .INIT_STATE(1)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
        .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
        .i_stall_from_issue(i_stall_from_issue), .i_pc_ff(i_pc_ff),
        .i_pc_plus_8_ff(i_pc_plus_8_ff), .i_instruction(i_instruction),
        .i_instruction_valid(i_instruction_valid), .i_upd_valid(i_upd_valid),
        .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
        .o_instruction_ff(o_instruction_ff), .o_instruction_valid_ff(o_instruction_valid_ff),
        .o_pc_ff(o_pc_ff), .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_taken_ff(o_taken_ff),
        .o_clear_from_decode(o_clear_from_decode), .o_pc_from_decode(o_pc_from_decode),
        .o_stall_from_decode(o_stall_from_decode), .o_init_done(o_init_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [INSN_W-1:0] insn, input logic [31:0] pc, input logic v);
        i_instruction       = insn;
        i_pc_ff             = pc;
        i_pc_plus_8_ff      = pc + 32'd8;
        i_instruction_valid = v;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken);
        i_upd_valid = 1'b1;
        i_upd_pc    = pc;
        i_upd_taken = taken;
        step();
        i_upd_valid = 1'b0;
    endtask

    task automatic count_sweep(output int cnt);
        cnt = 0;
        while (o_stall_from_decode && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_clear_from_writeback = 0; i_data_stall = 0; i_clear_from_alu = 0;
        i_stall_from_shifter = 0; i_stall_from_issue = 0;
        i_upd_valid = 0; i_upd_pc = 0; i_upd_taken = 0;
        drive('0, 32'd0, 1'b0);
        step();
        step();
        check_eq("rst_valid", o_instruction_valid_ff, 0);
        check_eq("rst_taken", o_taken_ff, 0);
        check_eq("rst_insn", o_instruction_ff, 0);
        check_eq("rst_pc", o_pc_ff, 0);
        check_eq("rst_pc8", o_pc_plus_8_ff, 0);
        check_eq("rst_stall", o_stall_from_decode, 1);
        check_eq("rst_done", o_init_done, 0);

        i_reset = 1'b0;
        count_sweep(n);
        check_eq("sweep_len", n, 16);
        check_eq("sweep_done", o_init_done, 1);

        // Reset mid-sweep restarts from entry 0
        i_reset = 1'b1; step(); i_reset = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check_eq("mid_stall", o_stall_from_decode, 1);
        i_reset = 1'b1; step(); i_reset = 1'b0;
        count_sweep(n);
        check_eq("resweep_len", n, 16);
        check_eq("resweep_stall", o_stall_from_decode, 0);

        // AL branch
        drive({3'b000, 32'hEA000002}, 32'h100, 1'b1);
        #1;
        check_eq("al_clear", o_clear_from_decode, 1);
        check_eq("al_target", o_pc_from_decode, 32'h110);
        step();
        check_eq("al_taken_ff", o_taken_ff, 3);
        check_eq("al_valid_ff", o_instruction_valid_ff, 1);
        check_eq("al_pc_ff", o_pc_ff, 32'h100);

        // Conditional BEQ at init counter value
        drive({3'b000, 32'h0AFFFFFE}, 32'h200, 1'b1);
        #1;
        check_eq("beq_wnt_clear", o_clear_from_decode, 0);
        check_eq("beq_wnt_pc", o_pc_from_decode, 0);
        step();
        check_eq("beq_wnt_taken_ff", o_taken_ff, 1);
        drive('0, 32'h0, 1'b0);
        upd(32'h200, 1'b1);
        upd(32'h200, 1'b1);
        drive({3'b000, 32'h0AFFFFFE}, 32'h200, 1'b1);
        #1;
        check_eq("beq_st_clear", o_clear_from_decode, 1);
        check_eq("beq_st_target", o_pc_from_decode, 32'h200);
        step();
        check_eq("beq_st_taken_ff", o_taken_ff, 3);

        // Same-cycle bypass at idx 5
        drive({3'b000, 32'h0A000000}, 32'h14, 1'b1);
        i_upd_valid = 1'b1; i_upd_pc = 32'h14; i_upd_taken = 1'b1;
        #1;
        check_eq("byp_clear", o_clear_from_decode, 1);
        check_eq("byp_target", o_pc_from_decode, 32'h1C);
        step();
        i_upd_valid = 1'b0;
        check_eq("byp_taken_ff", o_taken_ff, 2);
        drive('0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) upd(32'h14, 1'b0);
        drive({3'b000, 32'h0A000000}, 32'h14, 1'b1);
        #1;
        check_eq("sat0_clear", o_clear_from_decode, 0);
        step();
        check_eq("sat0_taken_ff", o_taken_ff, 0);

        // Halfword offset, target wraps below zero
        i_instruction = {1'b1, 2'b00, 32'hEAFFFFFF};
        i_pc_ff = 32'hFFFFFFF8; i_pc_plus_8_ff = 32'h0; i_instruction_valid = 1'b1;
        #1;
        check_eq("hw_clear", o_clear_from_decode, 1);
        check_eq("hw_target", o_pc_from_decode, 32'hFFFFFFFE);
        step();
        check_eq("hw_pc_ff", o_pc_ff, 32'hFFFFFFF8);

        // Data stall holds, writeback clear wins over stall
        drive({3'b000, 32'hEA000002}, 32'h100, 1'b1);
        i_data_stall = 1'b1;
        #1;
        check_eq("dstall_clear", o_clear_from_decode, 0);
        check_eq("dstall_pc", o_pc_from_decode, 0);
        step();
        check_eq("dstall_pc_ff", o_pc_ff, 32'hFFFFFFF8);
        check_eq("dstall_valid_ff", o_instruction_valid_ff, 1);
        check_eq("dstall_taken_ff", o_taken_ff, 3);
        i_clear_from_writeback = 1'b1;
        step();
        check_eq("wbclr_valid_ff", o_instruction_valid_ff, 0);
        check_eq("wbclr_taken_ff", o_taken_ff, 0);
        check_eq("wbclr_bit27", o_instruction_ff[27], 0);
        check_eq("wbclr_pc_ff", o_pc_ff, 32'hFFFFFFF8);
        i_clear_from_writeback = 1'b0; i_data_stall = 1'b0;

        // Issue stall holds a freshly loaded entry
        step();
        check_eq("load_pc_ff", o_pc_ff, 32'h100);
        drive({3'b000, 32'hEA000002}, 32'h300, 1'b1);
        i_stall_from_issue = 1'b1;
        step();
        check_eq("istall_pc_ff", o_pc_ff, 32'h100);
        i_stall_from_issue = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
